// File: rtl/pe_pkg.sv
// Shared PE-array definitions: control codes, transmitter FSM states, default id widths.
package pe_pkg;

    localparam int FID_W_DEF = 5;
    localparam int IID_W_DEF = 6;

    localparam logic [3:0] CTRL_IDLE        = 4'd0;
    localparam logic [3:0] CTRL_PROG        = 4'd1;
    localparam logic [3:0] CTRL_LOAD_FILTER = 4'd2;
    localparam logic [3:0] CTRL_LOAD_IFMAP  = 4'd3;
    localparam logic [3:0] CTRL_COMPUTE     = 4'd4;
    localparam logic [3:0] CTRL_PSUM_OUT    = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PROG     = 3'd1,
        ST_STREAM   = 3'd2,
        ST_COMPUTE  = 3'd3,
        ST_PSUM_OUT = 3'd4
    } gin_state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gin_xy_counter.sv
// Row-major PE coordinate walker: x advances fastest, wraps into y; last flags (GRID_X-1, GRID_Y-1).
module gin_xy_counter
    import pe_pkg::*;
#(
    parameter int GRID_X = 10,
    parameter int GRID_Y = 10,
    parameter int XW     = cnt_w(GRID_X),
    parameter int YW     = cnt_w(GRID_Y)
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          clr,
    input  logic          adv,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic x_wrap;
    logic y_wrap;

    assign x_wrap = (x == XW'(GRID_X - 1));
    assign y_wrap = (y == YW'(GRID_Y - 1));
    assign last   = x_wrap && y_wrap;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (x_wrap) begin
                x <= '0;
                y <= y_wrap ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/gin_transmitter.sv
// Global input network driver: programs PE ids, broadcasts tagged filter/ifmap words,
// then sequences compute and psum read-out.
module gin_transmitter
    import pe_pkg::*;
#(
    parameter int BITWIDTH = 16,
    parameter int GRID_X   = 10,
    parameter int GRID_Y   = 10,
    parameter int FID_W    = FID_W_DEF,
    parameter int IID_W    = IID_W_DEF,
    parameter int CYC_W    = 16
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       start,
    input  logic [CYC_W-1:0]           cfg_cycles,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_kind,
    input  logic [IID_W-1:0]           in_tag,
    input  logic signed [BITWIDTH-1:0] in_data,
    input  logic                       in_last,
    input  logic                       array_stall,
    output logic [3:0]                 control,
    output logic [FID_W-1:0]           filter_id,
    output logic [IID_W-1:0]           ifmap_id,
    output logic signed [BITWIDTH-1:0] filter,
    output logic signed [BITWIDTH-1:0] ifmap,
    output logic [GRID_X-1:0]          enable_x,
    output logic [GRID_Y-1:0]          enable_y,
    output logic                       busy,
    output logic                       done
);

    localparam int XW = cnt_w(GRID_X);
    localparam int YW = cnt_w(GRID_Y);

    if (GRID_X + GRID_Y - 2 >= (1 << IID_W)) begin : g_iid_check
        $error("ifmap_id = x+y does not fit IID_W");
    end
    if (GRID_Y - 1 >= (1 << FID_W)) begin : g_fid_check
        $error("filter_id = y does not fit FID_W");
    end
    if (FID_W > IID_W) begin : g_tag_check
        $error("filter tag slice wider than in_tag");
    end

    gin_state_e       state;
    logic [CYC_W-1:0] cyc_rem;
    logic [XW-1:0]    pe_x;
    logic [YW-1:0]    pe_y;
    logic             pe_last;
    logic             xfer_p0;

    gin_xy_counter #(
        .GRID_X (GRID_X),
        .GRID_Y (GRID_Y),
        .XW     (XW),
        .YW     (YW)
    ) u_xy (
        .clk  (clk),
        .rstb (rstb),
        .clr  (state == ST_IDLE),
        .adv  ((state == ST_PROG) && !array_stall),
        .x    (pe_x),
        .y    (pe_y),
        .last (pe_last)
    );

    assign in_ready = (state == ST_STREAM) && !array_stall;
    assign xfer_p0  = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= ST_IDLE;
            cyc_rem   <= '0;
            control   <= CTRL_IDLE;
            filter_id <= '0;
            ifmap_id  <= '0;
            filter    <= '0;
            ifmap     <= '0;
            enable_x  <= '0;
            enable_y  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    control  <= CTRL_IDLE;
                    enable_x <= '0;
                    enable_y <= '0;
                    if (start) begin
                        state   <= ST_PROG;
                        cyc_rem <= (cfg_cycles == '0) ? CYC_W'(1) : cfg_cycles;
                    end
                end
                ST_PROG: begin
                    if (!array_stall) begin
                        control   <= CTRL_PROG;
                        enable_x  <= GRID_X'(1) << pe_x;
                        enable_y  <= GRID_Y'(1) << pe_y;
                        filter_id <= FID_W'(pe_y);
                        ifmap_id  <= IID_W'(pe_x) + IID_W'(pe_y);
                        if (pe_last) state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (xfer_p0) begin
                        enable_x <= '1;
                        enable_y <= '1;
                        if (in_kind) begin
                            control  <= CTRL_LOAD_IFMAP;
                            ifmap_id <= in_tag;
                            ifmap    <= in_data;
                        end else begin
                            control   <= CTRL_LOAD_FILTER;
                            filter_id <= in_tag[FID_W-1:0];
                            filter    <= in_data;
                        end
                        if (in_last) state <= ST_COMPUTE;
                    end else begin
                        control  <= CTRL_IDLE;
                        enable_x <= '0;
                        enable_y <= '0;
                    end
                end
                ST_COMPUTE: begin
                    if (!array_stall) begin
                        control  <= CTRL_COMPUTE;
                        enable_x <= '1;
                        enable_y <= '1;
                        cyc_rem  <= cyc_rem - CYC_W'(1);
                        if (cyc_rem <= CYC_W'(1)) state <= ST_PSUM_OUT;
                    end
                end
                ST_PSUM_OUT: begin
                    control  <= CTRL_PSUM_OUT;
                    enable_x <= '1;
                    enable_y <= '1;
                    done     <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gin_transmitter.sv
// Scoreboard bench for gin_transmitter: stimulus pushes expected grid outputs, a monitor pops and compares.
module tb_gin_transmitter;
    import pe_pkg::*;

    localparam int BW = 16;
    localparam int GX = 10;
    localparam int GY = 10;
    localparam int FW = 5;
    localparam int IW = 6;
    localparam int CW = 16;

    logic                 clk = 1'b0;
    logic                 rstb;
    logic                 start;
    logic [CW-1:0]        cfg_cycles;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_kind;
    logic [IW-1:0]        in_tag;
    logic signed [BW-1:0] in_data;
    logic                 in_last;
    logic                 array_stall;
    logic [3:0]           control;
    logic [FW-1:0]        filter_id;
    logic [IW-1:0]        ifmap_id;
    logic signed [BW-1:0] filter;
    logic signed [BW-1:0] ifmap;
    logic [GX-1:0]        enable_x;
    logic [GY-1:0]        enable_y;
    logic                 busy;
    logic                 done;

    gin_transmitter #(
        .BITWIDTH (BW), .GRID_X (GX), .GRID_Y (GY),
        .FID_W (FW), .IID_W (IW), .CYC_W (CW)
    ) dut (
        .clk (clk), .rstb (rstb), .start (start), .cfg_cycles (cfg_cycles),
        .in_valid (in_valid), .in_ready (in_ready), .in_kind (in_kind),
        .in_tag (in_tag), .in_data (in_data), .in_last (in_last),
        .array_stall (array_stall), .control (control),
        .filter_id (filter_id), .ifmap_id (ifmap_id), .filter (filter),
        .ifmap (ifmap), .enable_x (enable_x), .enable_y (enable_y),
        .busy (busy), .done (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    ctrl;
        logic [GX-1:0] ex;
        logic [GY-1:0] ey;
        logic [FW-1:0] fid;
        logic [IW-1:0] iid;
        logic [BW-1:0] f;
        logic [BW-1:0] i;
        logic          dn;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   prog_idx = 0;
    bit   mon_en = 1'b0;
    logic stall_q = 1'b0;

    logic [FW-1:0] m_fid;
    logic [IW-1:0] m_iid;
    logic [BW-1:0] m_f;
    logic [BW-1:0] m_i;
    int            m_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic [GX-1:0] ex, input logic [GY-1:0] ey, input logic dn);
        exp_t e;
        e = '{ctrl: c, ex: ex, ey: ey, fid: m_fid, iid: m_iid, f: m_f, i: m_i, dn: dn};
        exp_q.push_back(e);
    endtask

    always @(posedge clk) stall_q <= array_stall;

    // Monitor: every fresh non-idle output (or done) consumes one expectation.
    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        if (mon_en && rstb) begin
            a = '{ctrl: control, ex: enable_x, ey: enable_y, fid: filter_id,
                  iid: ifmap_id, f: filter, i: ifmap, dn: done};
            if (stall_q) begin
            end else if (control != CTRL_IDLE || done) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got %h, expected nothing", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_err++;
                        $display("FAIL grid_output: got ctrl=%0d ex=%h ey=%h fid=%0d iid=%0d f=%0d i=%0d done=%b, expected ctrl=%0d ex=%h ey=%h fid=%0d iid=%0d f=%0d i=%0d done=%b",
                                 a.ctrl, a.ex, a.ey, a.fid, a.iid, $signed(a.f), $signed(a.i), a.dn,
                                 e.ctrl, e.ex, e.ey, e.fid, e.iid, $signed(e.f), $signed(e.i), e.dn);
                    end
                end
                if (control == CTRL_PROG) begin
                    if (prog_idx == 23) begin
                        chk("prog23_enable_x", 32'(enable_x), 32'h008);
                        chk("prog23_enable_y", 32'(enable_y), 32'h004);
                        chk("prog23_filter_id", 32'(filter_id), 32'd2);
                        chk("prog23_ifmap_id", 32'(ifmap_id), 32'd5);
                    end
                    prog_idx++;
                end
            end else begin
                prog_idx = 0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic start_job(input logic [CW-1:0] cyc);
        @(negedge clk);
        start = 1'b1;
        cfg_cycles = cyc;
        m_cyc = (cyc == 0) ? 1 : int'(cyc);
        for (int k = 0; k < GX * GY; k++) begin
            m_fid = FW'(k / GX);
            m_iid = IW'((k % GX) + (k / GX));
            push(CTRL_PROG, GX'(1) << (k % GX), GY'(1) << (k / GX), 1'b0);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_stream(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic kind, input logic [IW-1:0] tag, input logic [BW-1:0] data, input logic last);
        in_valid = 1'b1;
        in_kind = kind;
        in_tag = tag;
        in_data = data;
        in_last = last;
        #1;
        wait_stream("send");
        if (kind) begin
            m_iid = tag;
            m_i = data;
            push(CTRL_LOAD_IFMAP, '1, '1, 1'b0);
        end else begin
            m_fid = tag[FW-1:0];
            m_f = data;
            push(CTRL_LOAD_FILTER, '1, '1, 1'b0);
        end
        if (last) begin
            for (int c = 0; c < m_cyc; c++) push(CTRL_COMPUTE, '1, '1, 1'b0);
            push(CTRL_PSUM_OUT, '1, '1, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rstb = 1'b0;
        start = 1'b0;
        cfg_cycles = '0;
        in_valid = 1'b0;
        in_kind = 1'b0;
        in_tag = '0;
        in_data = '0;
        in_last = 1'b0;
        array_stall = 1'b0;
        m_fid = '0; m_iid = '0; m_f = '0; m_i = '0; m_cyc = 1;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        chk("reset_control", 32'(control), 32'(CTRL_IDLE));
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        // Asynchronous reset in the middle of programming.
        @(negedge clk);
        start = 1'b1;
        cfg_cycles = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("midprog_busy", 32'(busy), 32'd1);
        chk("midprog_control", 32'(control), 32'(CTRL_PROG));
        #2;
        rstb = 1'b0;
        #1;
        chk("async_rst_control", 32'(control), 32'(CTRL_IDLE));
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ids", {16'(filter_id), 16'(ifmap_id)}, 32'd0);
        chk("async_rst_enables", {16'(enable_x), 16'(enable_y)}, 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        mon_en = 1'b1;

        // Job A: programming with a stall, two stream words, 4 compute cycles with a stall.
        start_job(16'd4);
        repeat (30) @(negedge clk);
        array_stall = 1'b1;
        #1;
        chk("prog_stall_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        array_stall = 1'b0;
        wait_stream("jobA_prog");
        @(negedge clk);
        chk("after_prog_control", 32'(control), 32'(CTRL_IDLE));
        chk("after_prog_in_ready", 32'(in_ready), 32'd1);
        send(1'b0, 6'd3, -16'sd7, 1'b0);
        send(1'b1, 6'd12, 16'sd100, 1'b1);
        @(negedge clk);
        array_stall = 1'b1;
        repeat (2) @(negedge clk);
        array_stall = 1'b0;
        wait_idle("jobA");
        chk("jobA_done_count", 32'(done_cnt), 32'd1);
        chk("jobA_idle_in_ready", 32'(in_ready), 32'd0);

        // Job B: stalled stream word, start while busy, extreme data, cfg_cycles=0.
        start_job(16'd0);
        wait_stream("jobB_prog");
        @(negedge clk);
        array_stall = 1'b1;
        in_valid = 1'b1;
        in_kind = 1'b0;
        in_tag = 6'd7;
        in_data = 16'sh7FFF;
        in_last = 1'b1;
        #1;
        chk("stream_stall_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        array_stall = 1'b0;
        send(1'b0, 6'd7, 16'sh7FFF, 1'b0);
        start = 1'b1;
        cfg_cycles = 16'd9;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_stream_busy", 32'(busy), 32'd1);
        send(1'b1, 6'd63, 16'sh8000, 1'b1);
        wait_idle("jobB");
        chk("jobB_done_count", 32'(done_cnt), 32'd2);

        repeat (5) @(negedge clk);
        chk("leftover_expectations", 32'(exp_q.size()), 32'd0);
        chk("final_done_count", 32'(done_cnt), 32'd2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
